// File: rtl/receiver_pkg.sv
// receiver_pkg: shared types and default frame constants for the serial receiver.
//   rx_state_t  - receive FSM states
//   DATA_BITS   - data bits per frame
//   OVERSAMPLE  - clk cycles per serial bit
//   START_CHECK - bit-sample count at which the start bit is re-checked
//   FRAME_BITS  - start + data + stop bits
package receiver_pkg;

   localparam int DATA_BITS   = 8;
   localparam int OVERSAMPLE  = 16;
   localparam int START_CHECK = 7;
   localparam int FRAME_BITS  = DATA_BITS + 2;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

endpackage

// File: rtl/receiver_serial_to_parallel.sv
// serial_to_parallel: right-shift register that assembles LSB-first serial data.
//   clk          - rising-edge clock
//   rst          - asynchronous active-high reset, clears the register
//   clear        - synchronous clear (wins over shift)
//   shift        - shift serial_in into the MSB, moving everything one place right
//   serial_in    - incoming bit
//   parallel_out - current register contents
module serial_to_parallel #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             shift,
   input  logic             serial_in,
   output logic [WIDTH-1:0] parallel_out
);

   logic [WIDTH-1:0] sreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg <= '0;
      end else if (clear) begin
         sreg <= '0;
      end else if (shift) begin
         sreg <= {serial_in, sreg[WIDTH-1:1]};
      end
   end

   assign parallel_out = sreg;

endmodule

// File: rtl/receiver.sv
// receiver: recovers 10-bit async frames (start 0, data LSB first, stop 1) from a
// 16x-oversampled serial line and holds each byte for the host.
//   clk            - single clock, rising edge
//   rst            - asynchronous active-high reset
//   data_in        - serial line (asynchronous to clk, idles high)
//   receive_enable - high permits reception; low aborts any frame in flight
//   read           - host strobe consuming the held byte
//   data_out       - last received byte
//   data_valid     - byte held and not yet read
//   framing_error  - last frame's stop bit sampled 0
//   overrun_error  - an unread byte was overwritten
module receiver #(
   parameter int DATA_BITS   = receiver_pkg::DATA_BITS,
   parameter int OVERSAMPLE  = receiver_pkg::OVERSAMPLE,
   parameter int START_CHECK = receiver_pkg::START_CHECK
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 data_in,
   input  logic                 receive_enable,
   input  logic                 read,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 framing_error,
   output logic                 overrun_error
);

   import receiver_pkg::*;

   localparam int BSC_W = $clog2(OVERSAMPLE);
   localparam int BIC_W = $clog2(DATA_BITS + 1);

   localparam logic [BSC_W-1:0] BSC_LAST  = BSC_W'(OVERSAMPLE - 1);
   localparam logic [BSC_W-1:0] BSC_CHECK = BSC_W'(START_CHECK);
   localparam logic [BIC_W-1:0] BIC_LAST  = BIC_W'(DATA_BITS - 1);

   rx_state_t        state_q, state_d;
   logic [BSC_W-1:0] bsc_q, bsc_d;
   logic [BIC_W-1:0] bic_q, bic_d;

   logic sync1, rx_s, rx_prev;
   logic shift, clear_sr, complete;
   logic [DATA_BITS-1:0] shift_data;

   // Synchronizer plus one extra stage for falling-edge detection; all idle high so
   // reset never looks like a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= data_in;
         rx_s    <= sync1;
         rx_prev <= rx_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         bsc_q   <= '0;
         bic_q   <= '0;
      end else begin
         state_q <= state_d;
         bsc_q   <= bsc_d;
         bic_q   <= bic_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bsc_d    = bsc_q;
      bic_d    = bic_q;
      shift    = 1'b0;
      clear_sr = 1'b0;
      complete = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Needs a real high-to-low edge: a line stuck low never starts a frame.
            if (receive_enable && rx_prev && !rx_s) begin
               state_d  = START;
               bsc_d    = '0;
               clear_sr = 1'b1;
            end
         end
         START: begin
            if (!receive_enable) begin
               state_d = IDLE;
            end else if (bsc_q == BSC_CHECK) begin
               if (rx_s) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  bsc_d   = '0;
                  bic_d   = '0;
               end
            end else begin
               bsc_d = bsc_q + 1'b1;
            end
         end
         DATA: begin
            if (!receive_enable) begin
               state_d = IDLE;
            end else begin
               bsc_d = (bsc_q == BSC_LAST) ? '0 : bsc_q + 1'b1;
               if (bsc_q == BSC_LAST) begin
                  shift = 1'b1;
                  bic_d = bic_q + 1'b1;
                  if (bic_q == BIC_LAST) begin
                     state_d = STOP;
                  end
               end
            end
         end
         STOP: begin
            if (!receive_enable) begin
               state_d = IDLE;
            end else begin
               bsc_d = (bsc_q == BSC_LAST) ? '0 : bsc_q + 1'b1;
               if (bsc_q == BSC_LAST) begin
                  complete = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   serial_to_parallel #(
      .WIDTH(DATA_BITS)
   ) u_s2p (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear_sr),
      .shift       (shift),
      .serial_in   (rx_s),
      .parallel_out(shift_data)
   );

   // Host-facing registers. A completion coinciding with read delivers the new
   // byte and is not an overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out      <= '0;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
         overrun_error <= 1'b0;
      end else if (complete) begin
         data_out      <= shift_data;
         data_valid    <= 1'b1;
         framing_error <= ~rx_s;
         if (data_valid && !read) begin
            overrun_error <= 1'b1;
         end
      end else if (read) begin
         data_valid    <= 1'b0;
         overrun_error <= 1'b0;
      end
   end

endmodule

// File: doc/receiver.md
# receiver

Serial receive stage: reassembles 10-bit asynchronous frames (start 0, 8 data bits LSB first, stop 1, line idles high) from a 16x-oversampled serial line into bytes.

- Sits directly downstream of `transmitter`.
- Consumes `transmitter.data_out` at the same 16-clocks-per-bit rate.
- Presents each byte to the host with a valid/read handshake and error flags.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame.
- `OVERSAMPLE`, default 16: `clk` cycles per bit.
- `START_CHECK`, default 7: `bsc` value at which the start bit is re-checked.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  1  serial line, asynchronous to `clk`.
- `receive_enable`  in  1  high permits reception.
- `read`  in  1  host strobe that consumes the held byte.
- `data_out`  out  8  last received byte.
- `data_valid`  out  1  byte held and not yet read.
- `framing_error`  out  1  last frame's stop bit sampled 0.
- `overrun_error`  out  1  an unread byte was overwritten.

## Operation
- **Synchronizer:** 2-flop on `data_in`, giving `rx_s`. A third flop `rx_prev` is used for edge detection. All three reset to 1.
- **State machine:** IDLE, START, DATA, STOP.
- **IDLE:**
  - Requires `receive_enable` = 1, `rx_prev` = 1 and `rx_s` = 0 (a falling edge) to move to START.
  - On entry to START, clear `bsc`.
  - A line held low (after a framing error) never starts a frame until it has returned high.
- **START:**
  - `bsc` increments every cycle.
  - At `bsc == START_CHECK`: if `rx_s` = 1, the start was a glitch; return to IDLE with no output change.
  - Otherwise go to DATA and clear `bsc` and `bic`.
- **DATA:**
  - `bsc` counts 0..15 and wraps.
  - At `bsc == 15`, shift `rx_s` into the shift register MSB (right shift, so LSB-first data lands correctly) and increment `bic`.
  - After the 8th bit, go to STOP.
- **STOP:** at `bsc == 15`, sample `rx_s` as the stop bit, perform the completion update, then return to IDLE.
- **Completion update** (single cycle):
  - `data_out` <= shift register.
  - `data_valid` <= 1.
  - `framing_error` <= ~stop sample.
  - `overrun_error` <= 1 if `data_valid` was 1 and `read` = 0 this cycle; otherwise it keeps its value.
  - The byte is delivered even on a framing error.
- **`read`:**
  - When `read` = 1 with no completion: clears `data_valid` and `overrun_error`. `data_out` holds its value.
  - When `read` = 1 coincides with a completion: the new byte wins, `data_valid` stays 1, and no overrun is flagged.
- **`receive_enable`:** if it drops in START, DATA or STOP, abort to IDLE; the partial byte is discarded and outputs are unchanged.
- **Reset:** state IDLE, counters 0, shift register 0, `data_out` 0x00, `data_valid` 0, `framing_error` 0, `overrun_error` 0. Reset mid-frame discards the frame.

## Timing
- Let E0 be the first `clk` edge that samples `data_in` low. Then:
  - E2: enter START.
  - E10: start bit confirmed.
  - E10+16k, k = 1..8: data bits sampled.
  - E154: stop bit sampled.
- Each sample point lands 10 cycles into its 16-cycle bit cell.
- `data_valid` and `data_out` change together and are visible after edge E154 (154 cycles after E0).
- Minimum idle between frames is 0 stop-extension cycles. Back-to-back frames from `transmitter` (start edge 6 cycles after the stop sample) are received without loss.
- `read` takes effect on the edge it is sampled; `data_valid` is low the following cycle.
- Counter widths:
  - `bsc`: $clog2(OVERSAMPLE) bits, 4 at default.
  - `bic`: $clog2(DATA_BITS+1) bits, 4 at default.
  - No arithmetic overflow is possible beyond the defined wrap of `bsc`.

## Structure
- Package `receiver_pkg`:
  - State enum `rx_state_t` (IDLE, START, DATA, STOP).
  - Constants `OVERSAMPLE`, `START_CHECK`, `DATA_BITS`, `FRAME_BITS` (10).
- Sub-module `serial_to_parallel`: 8-bit right-shift register with `shift` enable, `clear`, serial in, parallel out.
- FSM, synchronizer and `bsc`/`bic` counters live in `receiver`.

## Test plan
- **Single frame:** reset, `receive_enable` = 1, drive frame 0x9B (10011011) at 16 clk/bit.
  - `data_out` = 0x9B.
  - `data_valid` rises exactly 154 edges after the start edge.
  - `framing_error` = 0.
- **Glitch:** drive a 5-cycle low pulse on an idle line → FSM returns to IDLE and `data_valid` stays 0. A subsequent frame 0x3C is received correctly.
- **Framing error:** drive 0xA5 with stop bit 0 and keep the line low for 40 cycles, then high.
  - `data_out` = 0xA5, `data_valid` = 1, `framing_error` = 1.
  - No new frame starts until the line returns high.
- **Overrun:** drive 0x11 then 0x22 back-to-back with no `read` → `data_out` = 0x22, `overrun_error` = 1. A subsequent `read` clears both `data_valid` and `overrun_error`.
- **Read collision:** assert `read` on the completion cycle of 0x55 while 0x11 is held → `data_valid` = 1, `data_out` = 0x55, `overrun_error` = 0.
- **Abort and reset:**
  - Drop `receive_enable` at bit 4 → no output change.
  - Assert `rst` mid-frame → all outputs 0 and the next frame is received normally.
  - Run 300 back-to-back frames from `transmitter` (0x9B) → 300 `data_valid` completions, all equal to 0x9B.
